// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - write-port arbiter for the 32x32 register file
//
// Purpose: shares the single register-file write port among NUM_REQ
//   writeback requesters. At most one requester is granted per cycle,
//   round-robin by default. The winner's (index, data) is registered as the
//   write command one cycle after acceptance. Writes to r0 are consumed, but
//   the write enable stays low.
// Build option: define REGARB_FIXED_PRIO_EN for fixed priority, where the
//   lowest-index valid requester always wins. With this option the
//   round-robin pointer is not built.
// Ports:
//   clk              - rising-edge clock
//   reset            - asynchronous active-low reset
//   wr_stall         - pipeline freeze; blocks all grants while 1
//   req_valid        - per-requester write request
//   req_addr         - packed register indices, requester i at [i*ADDR_W +: ADDR_W]
//   req_data         - packed write data, requester i at [i*DATA_W +: DATA_W]
//   req_ready        - one-hot combinational grant
//   ctrl_writeEnable - registered register-file write enable
//   ctrl_writeReg    - registered register-file write index
//   data_writeReg    - registered register-file write data
module regfile_write_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_stall,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      ctrl_writeEnable,
  output logic [ADDR_W-1:0]         ctrl_writeReg,
  output logic [DATA_W-1:0]         data_writeReg
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]   basePtr;
  logic [PTR_W-1:0]   grantIdx;
  logic               grantFound;
  logic [NUM_REQ-1:0] grantOneHot;
  logic [ADDR_W-1:0]  grantAddr;
  logic [DATA_W-1:0]  grantData;

`ifdef REGARB_FIXED_PRIO_EN
  assign basePtr = '0;
`else
  logic [PTR_W-1:0] rrPtr;

  assign basePtr = rrPtr;

  // The pointer moves just past the winner, including for r0 writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rrPtr <= '0;
    end else if (grantFound) begin
      rrPtr <= (grantIdx == PTR_W'(NUM_REQ - 1)) ? '0 : grantIdx + PTR_W'(1);
    end
  end
`endif

  // Two-pass search. The first pass picks the lowest valid index overall,
  // which is the wrap-around winner. The second pass overrides it with the
  // lowest valid index at or above basePtr, if there is one.
  // Reset is folded in so that ready stays low while reset is asserted.
  always_comb begin
    grantIdx   = '0;
    grantFound = 1'b0;
    if (reset && !wr_stall) begin
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        if (req_valid[i]) begin
          grantIdx   = PTR_W'(i);
          grantFound = 1'b1;
        end
      end
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        if (req_valid[i] && (i >= int'(basePtr))) begin
          grantIdx = PTR_W'(i);
        end
      end
    end
  end

  always_comb begin
    grantOneHot = '0;
    grantAddr   = '0;
    grantData   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grantFound && (grantIdx == PTR_W'(i))) begin
        grantOneHot[i] = 1'b1;
        grantAddr      = req_addr[i*ADDR_W +: ADDR_W];
        grantData      = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign req_ready = grantOneHot;

  // A grant is only issued to a valid requester, so grantFound marks a transfer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_writeEnable <= 1'b0;
      ctrl_writeReg    <= '0;
      data_writeReg    <= '0;
    end else if (grantFound) begin
      ctrl_writeEnable <= (grantAddr != '0);
      ctrl_writeReg    <= grantAddr;
      data_writeReg    <= grantData;
    end else begin
      ctrl_writeEnable <= 1'b0;
    end
  end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single register-file write port among several writeback requesters, such as ALU writeback, the multiply/divide unit completion and the exception/status write. Each requester presents a valid/ready handshake. The block grants at most one requester per cycle, round-robin by default, and drives a registered write command (enable, register index, data) to the 32x32 register file.

## Interface
Parameters:
- NUM_REQ, 3, number of requesters (2..8)
- ADDR_W, 5, register index width
- DATA_W, 32, write data width

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- wr_stall  input  1  pipeline freeze; 1 blocks all grants
- req_valid  input  NUM_REQ  per-requester write request
- req_addr  input  NUM_REQ*ADDR_W  packed register index; requester i at [i*ADDR_W +: ADDR_W]
- req_data  input  NUM_REQ*DATA_W  packed write data; requester i at [i*DATA_W +: DATA_W]
- req_ready  output  NUM_REQ  one-hot grant (combinational); transfer occurs when req_valid[i] & req_ready[i]
- ctrl_writeEnable  output  1  register-file write enable (registered)
- ctrl_writeReg  output  ADDR_W  register-file write index (registered)
- data_writeReg  output  DATA_W  register-file write data (registered)

## Operation
- State:
  - rr_ptr: index of the highest-priority requester, range 0..NUM_REQ-1.
  - Output registers.
- Grant, evaluated every cycle:
  - If wr_stall=1 or no req_valid bit is set, req_ready is all zeros.
  - Otherwise, req_ready has exactly one bit set: the first set req_valid bit found searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
- req_ready depends only on req_valid, wr_stall and rr_ptr; it never depends on addr or data.
- On the clock edge following a transfer from requester g:
  - ctrl_writeReg and data_writeReg load the addr and data of requester g.
  - ctrl_writeEnable = 1, unless the addr is 0. A write to r0 is accepted and consumed (ready=1), but ctrl_writeEnable = 0.
  - rr_ptr = (g+1) mod NUM_REQ. The pointer advances for r0 writes too.
- With no transfer in a cycle:
  - ctrl_writeEnable = 0 on the next edge.
  - ctrl_writeReg and data_writeReg hold their previous values.
  - rr_ptr holds.
- Requesters must hold valid, addr and data stable until accepted. The arbiter does not buffer unaccepted requests.
- Same-address requests in one cycle: they serialize in grant order, so the last granted wins in the register file.

## Timing
- Grant latency: combinational within the request cycle.
- Write latency: ctrl_* is asserted exactly 1 cycle after acceptance.
- Throughput: one write per cycle while requests are pending.
- Wait bound: a continuously valid requester waits at most NUM_REQ-1 grant cycles (round-robin mode).
- wr_stall:
  - A rising wr_stall suppresses grants in that same cycle.
  - A write already registered from the previous cycle still completes.
- Reset, asynchronous, while reset=0:
  - ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0, rr_ptr=0.
  - req_ready=0 while reset is asserted.
  - Reset asserted mid-transfer discards the registered write immediately.
- Release: the first grant is possible in the first cycle with reset=1.

## Configuration
- REGARB_FIXED_PRIO_EN
  - Defined: fixed priority. The lowest-index valid requester always wins, rr_ptr is not implemented and grants ignore history. Starvation of higher indices is permitted.
  - Undefined (default): round-robin as described above.
- All other behavior (r0 suppression, stall, latency, reset) is identical in both modes.

## Test plan
- Reset: hold reset=0 with req_valid=3'b111 -> req_ready=0 and all ctrl_* = 0. Release reset -> req_ready=3'b001; next cycle ctrl_writeEnable=1 with requester 0's addr and data.
- Round-robin: all three requesters continuously valid, addrs 1/2/3, data 0xA/0xB/0xC -> grants 0,1,2,0,1,2; ctrl_writeReg sequence 1,2,3,1,2,3, each one cycle after its grant.
- r0 filter: requester 1 alone with addr 0, data 0xDEADBEEF -> req_ready[1]=1; next cycle ctrl_writeEnable=0; then requester 1 and requester 2 valid -> requester 2 granted first (pointer advanced past 1).
- Stall: requester 0 valid, wr_stall=1 for 3 cycles -> req_ready=0 and ctrl_writeEnable=0 throughout; stall drops -> grant in that cycle, write in the next.
- Async reset mid-write: grant requester 2 (addr 7, data 0x55) and assert reset=0 mid-cycle after the edge -> ctrl_writeEnable falls to 0 immediately without waiting for clk; rr_ptr returns to 0.
- REGARB_FIXED_PRIO_EN defined, all valid for 4 cycles -> requester 0 granted every cycle; drop requester 0 -> requester 1 granted.
